// File: rtl/rpn_pkg.sv
// rpn_pkg: shared types for the RPN stack engine.
//   rpn_op_e      - 3-bit command opcode (RPN_NOP..RPN_SWAP)
//   rpn_state_e   - engine FSM state (IDLE, MUL, WB)
//   MIN_DEPTH_*   - operands each opcode needs on the stack
//   rpn_min_depth - opcode -> minimum stack occupancy lookup
package rpn_pkg;

  typedef enum logic [2:0] {
    RPN_NOP  = 3'd0,
    RPN_PUSH = 3'd1,
    RPN_POP  = 3'd2,
    RPN_ADD  = 3'd3,
    RPN_SUB  = 3'd4,
    RPN_MUL  = 3'd5,
    RPN_DUP  = 3'd6,
    RPN_SWAP = 3'd7
  } rpn_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } rpn_state_e;

  localparam int unsigned MIN_DEPTH_NONE   = 0;
  localparam int unsigned MIN_DEPTH_UNARY  = 1;
  localparam int unsigned MIN_DEPTH_BINARY = 2;

  function automatic int unsigned rpn_min_depth(input rpn_op_e op);
    case (op)
      RPN_POP, RPN_DUP:                   return MIN_DEPTH_UNARY;
      RPN_ADD, RPN_SUB, RPN_MUL, RPN_SWAP: return MIN_DEPTH_BINARY;
      default:                            return MIN_DEPTH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rpn_seq_mult.sv
// rpn_seq_mult: unsigned shift-add multiplier, one partial product per cycle.
//   clock, reset_n : clock, asynchronous active-low reset
//   start          : latch a/b and begin; ignored while busy is irrelevant
//                    because the engine only starts it from IDLE
//   a, b           : unsigned operands (multiplicand, multiplier)
//   done           : high during the last of the DATA_W iterations; product
//                    holds the full result from the following cycle on
//   product        : 2*DATA_W-bit accumulator
module rpn_seq_mult #(
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int IT_W = $clog2(DATA_W + 1);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(DATA_W - 1);

  logic                busy_q, busy_d;
  logic [IT_W-1:0]     it_q, it_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;

  always_comb begin
    busy_d   = busy_q;
    it_d     = it_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    if (start) begin
      busy_d   = 1'b1;
      it_d     = '0;
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
    end else if (busy_q) begin
      // Add the shifted multiplicand for each set multiplier bit, LSB first.
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      it_d     = it_q + IT_W'(1);
      if (it_q == LAST_IT) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      it_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      it_q     <= it_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
    end
  end

  assign done    = busy_q && (it_q == LAST_IT);
  assign product = acc_q;

endmodule

// File: rtl/rpn_stack_engine.sv
// rpn_stack_engine: DATA_W-wide, DEPTH-entry RPN operand stack with a
// valid/ready opcode port, occupancy count and sticky error flags.
//   clock, reset_n       : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (ready only while IDLE)
//   cmd_op, cmd_value    : opcode (rpn_op_e) and PUSH operand
//   err_clear            : clears the sticky error flags
//   stack0, stack1       : top and second stack entries
//   depth                : number of valid entries, 0..DEPTH
//   err_overflow         : PUSH/DUP attempted while full (sticky)
//   err_underflow        : op issued with too few operands (sticky)
//   err_saturate         : only when RPN_SAT_EN is defined; an ADD/SUB/MUL
//                          result was clamped (sticky)
// Build option RPN_SAT_EN: signed saturation for ADD/SUB, all-ones clamp for
// MUL when the product exceeds DATA_W bits. Undefined: results wrap.
module rpn_stack_engine
  import rpn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_value,
  input  logic              err_clear,
  output logic [DATA_W-1:0] stack0,
  output logic [DATA_W-1:0] stack1,
  output logic [CNT_W-1:0]  depth,
  output logic              err_overflow,
  output logic              err_underflow
`ifdef RPN_SAT_EN
  ,
  output logic              err_saturate
`endif
);

  rpn_state_e          state_q, state_d;
  logic [DATA_W-1:0]   stk_q [DEPTH];
  logic [DATA_W-1:0]   stk_d [DEPTH];
  logic [CNT_W-1:0]    depth_q, depth_d;
  logic                ovf_q, ovf_d, udf_q, udf_d;

  rpn_op_e             op;
  logic                accept, short_ops, full, mul_start;
  logic                mult_done;
  logic [2*DATA_W-1:0] mult_product;

  logic [DATA_W-1:0]   add_res, sub_res, mul_res;

  logic                ovf_set, udf_set;
  logic                push_en, bin_en;
  logic [DATA_W-1:0]   push_val, bin_res;

`ifdef RPN_SAT_EN
  logic sat_q, sat_d, sat_set;
  logic add_sat, sub_sat, mul_sat;

  // Signed add with clamp; MSB of the return value flags a clamp.
  function automatic logic [DATA_W:0] sat_add(input logic signed [DATA_W-1:0] x,
                                              input logic signed [DATA_W-1:0] y);
    logic signed [DATA_W:0] s;
    s = {x[DATA_W-1], x} + {y[DATA_W-1], y};
    if (s[DATA_W] != s[DATA_W-1])
      return {1'b1, s[DATA_W], {(DATA_W-1){~s[DATA_W]}}};
    return {1'b0, s[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W:0] sat_sub(input logic signed [DATA_W-1:0] x,
                                              input logic signed [DATA_W-1:0] y);
    logic signed [DATA_W:0] s;
    s = {x[DATA_W-1], x} - {y[DATA_W-1], y};
    if (s[DATA_W] != s[DATA_W-1])
      return {1'b1, s[DATA_W], {(DATA_W-1){~s[DATA_W]}}};
    return {1'b0, s[DATA_W-1:0]};
  endfunction

  function automatic logic [DATA_W:0] sat_mul(input logic [2*DATA_W-1:0] p);
    if (|p[2*DATA_W-1:DATA_W]) return {1'b1, {DATA_W{1'b1}}};
    return {1'b0, p[DATA_W-1:0]};
  endfunction

  assign {add_sat, add_res} = sat_add(stk_q[1], stk_q[0]);
  assign {sub_sat, sub_res} = sat_sub(stk_q[1], stk_q[0]);
  assign {mul_sat, mul_res} = sat_mul(mult_product);
`else
  // Keep the low half only; the upper half is what wrap discards.
  function automatic logic [DATA_W-1:0] wrap_mul(input logic [2*DATA_W-1:0] p);
    return p[DATA_W-1:0];
  endfunction

  assign add_res = stk_q[1] + stk_q[0];
  assign sub_res = stk_q[1] - stk_q[0];
  assign mul_res = wrap_mul(mult_product);
`endif

  assign op        = rpn_op_e'(cmd_op);
  assign accept    = cmd_valid && cmd_ready;
  assign short_ops = depth_q < CNT_W'(rpn_min_depth(op));
  assign full      = depth_q == CNT_W'(DEPTH);

  rpn_seq_mult #(.DATA_W(DATA_W)) u_mult (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (mul_start),
    .a       (stk_q[0]),
    .b       (stk_q[1]),
    .done    (mult_done),
    .product (mult_product)
  );

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && op == RPN_MUL && !short_ops) state_d = ST_MUL;
      ST_MUL:  if (mult_done) state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    mul_start = (state_q == ST_IDLE) && cmd_valid && (op == RPN_MUL) && !short_ops;
  end

  // Stack datapath and error flags
  always_comb begin
    stk_d    = stk_q;
    depth_d  = depth_q;
    ovf_set  = 1'b0;
    udf_set  = 1'b0;
    push_en  = 1'b0;
    push_val = cmd_value;
    bin_en   = 1'b0;
    bin_res  = add_res;
`ifdef RPN_SAT_EN
    sat_set  = 1'b0;
`endif
    if (accept) begin
      if (short_ops) begin
        udf_set = 1'b1;
      end else begin
        case (op)
          RPN_PUSH: begin
            if (full) ovf_set = 1'b1;
            else begin push_en = 1'b1; push_val = cmd_value; end
          end
          RPN_DUP: begin
            if (full) ovf_set = 1'b1;
            else begin push_en = 1'b1; push_val = stk_q[0]; end
          end
          RPN_POP: begin
            for (int i = 0; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[DEPTH-1] = '0;
            depth_d = depth_q - CNT_W'(1);
          end
          RPN_SWAP: begin
            stk_d[0] = stk_q[1];
            stk_d[1] = stk_q[0];
          end
          RPN_ADD: begin
            bin_en  = 1'b1;
            bin_res = add_res;
`ifdef RPN_SAT_EN
            sat_set = add_sat;
`endif
          end
          RPN_SUB: begin
            bin_en  = 1'b1;
            bin_res = sub_res;
`ifdef RPN_SAT_EN
            sat_set = sub_sat;
`endif
          end
          default: ;  // NOP; MUL is started by the FSM and written back in WB
        endcase
      end
    end else if (state_q == ST_WB) begin
      bin_en  = 1'b1;
      bin_res = mul_res;
`ifdef RPN_SAT_EN
      sat_set = mul_sat;
`endif
    end

    if (push_en) begin
      for (int i = DEPTH - 1; i > 0; i--) stk_d[i] = stk_q[i-1];
      stk_d[0] = push_val;
      depth_d  = depth_q + CNT_W'(1);
    end

    // Two operands consumed, one result pushed: entries 2.. move up by one.
    if (bin_en) begin
      stk_d[0] = bin_res;
      for (int i = 1; i < DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
      stk_d[DEPTH-1] = '0;
      depth_d = depth_q - CNT_W'(1);
    end

    // A new error in the clearing cycle wins over the clear.
    ovf_d = (ovf_q & ~err_clear) | ovf_set;
    udf_d = (udf_q & ~err_clear) | udf_set;
`ifdef RPN_SAT_EN
    sat_d = (sat_q & ~err_clear) | sat_set;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
`ifdef RPN_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      stk_q   <= stk_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
`ifdef RPN_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign stack0        = stk_q[0];
  assign stack1        = stk_q[1];
  assign depth         = depth_q;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
`ifdef RPN_SAT_EN
  assign err_saturate  = sat_q;
`endif

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Scoreboard bench for rpn_stack_engine (DATA_W=32, DEPTH=4). The driver
// updates a queue-based stack model and pushes the expected outcome; the
// monitor pops and compares each time an accepted command completes.
module tb_rpn_stack_engine;
  import rpn_pkg::*;

  localparam int DW = 32;
  localparam int DP = 4;
  localparam int CW = $clog2(DP + 1);

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [DW-1:0] cmd_value = '0;
  logic          err_clear = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] stack0, stack1;
  logic [CW-1:0] depth;
  logic          err_overflow, err_underflow;
`ifdef RPN_SAT_EN
  logic          err_saturate;
`endif

  rpn_stack_engine #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_value     (cmd_value),
    .err_clear     (err_clear),
    .stack0        (stack0),
    .stack1        (stack1),
    .depth         (depth),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef RPN_SAT_EN
    ,
    .err_saturate  (err_saturate)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] s0;
    logic [DW-1:0] s1;
    int            d;
    logic          o;
    logic          u;
    logic          sat;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m[$];      // model stack, m[0] is the top
  logic          m_o = 1'b0, m_u = 1'b0, m_s = 1'b0;
  int            checks = 0;
  int            errors = 0;
  logic          acc_seen;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Accept happens on the edge where cmd_valid && cmd_ready.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) acc_seen <= 1'b0;
    else          acc_seen <= cmd_valid && cmd_ready;
  end

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] val, input logic clr);
    exp_t            e;
    int              n;
    int              guard;
    logic            o, u, s;
    logic [DW-1:0]   a, b, r, t;
    logic [2*DW-1:0] p;
    longint          sr;
    guard = 0; o = 1'b0; u = 1'b0; s = 1'b0; r = '0;
    @(negedge clock);
    while (!cmd_ready) begin
      guard++;
      if (guard > 200) begin
        checks++; errors++;
        $display("FAIL ready_wait: cmd_ready stuck at %0b, required 1", cmd_ready);
        return;
      end
      @(negedge clock);
    end
    n = m.size();
    e.lat = 0;
    case (rpn_op_e'(op))
      RPN_PUSH: if (n == DP) o = 1'b1; else m.push_front(val);
      RPN_POP:  if (n < 1) u = 1'b1; else void'(m.pop_front());
      RPN_DUP:  if (n < 1) u = 1'b1; else if (n == DP) o = 1'b1; else m.push_front(m[0]);
      RPN_SWAP: if (n < 2) u = 1'b1; else begin t = m[0]; m[0] = m[1]; m[1] = t; end
      RPN_ADD, RPN_SUB, RPN_MUL: begin
        if (n < 2) u = 1'b1;
        else begin
          a = m.pop_front();
          b = m.pop_front();
          if (rpn_op_e'(op) == RPN_ADD) begin
            r  = b + a;
            sr = longint'($signed(b)) + longint'($signed(a));
          end else if (rpn_op_e'(op) == RPN_SUB) begin
            r  = b - a;
            sr = longint'($signed(b)) - longint'($signed(a));
          end else begin
            p  = {32'd0, b} * {32'd0, a};
            r  = p[DW-1:0];
            sr = 0;
            e.lat = DW + 1;
`ifdef RPN_SAT_EN
            if (p[2*DW-1:DW] != 0) begin r = '1; s = 1'b1; end
`endif
          end
`ifdef RPN_SAT_EN
          if (rpn_op_e'(op) != RPN_MUL) begin
            if (sr > 64'sd2147483647)       begin r = 32'h7FFF_FFFF; s = 1'b1; end
            else if (sr < -64'sd2147483648) begin r = 32'h8000_0000; s = 1'b1; end
          end
`else
          if (sr == 64'sd1) r = r;  // signed view only matters with saturation
`endif
          m.push_front(r);
        end
      end
      default: ;
    endcase
    m_o = (m_o & ~clr) | o;
    m_u = (m_u & ~clr) | u;
    m_s = (m_s & ~clr) | s;
    e.d   = m.size();
    e.s0  = (m.size() > 0) ? m[0] : '0;
    e.s1  = (m.size() > 1) ? m[1] : '0;
    e.o   = m_o;
    e.u   = m_u;
    e.sat = m_s;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_op = op; cmd_value = val; err_clear = clr;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0; err_clear = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 200) begin @(negedge clock); g++; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clock);
  endtask

  task automatic clear_errors();
    @(negedge clock);
    err_clear = 1'b1;
    @(posedge clock);
    #1;
    err_clear = 1'b0;
    m_o = 1'b0; m_u = 1'b0; m_s = 1'b0;
    chk("clear_ovf", 64'(err_overflow), 64'(0));
    chk("clear_udf", 64'(err_underflow), 64'(0));
  endtask

  // Monitor: a completion is the first cycle with cmd_ready high after an accept.
  initial begin : monitor
    int   wait_cnt;
    bit   pending;
    exp_t e;
    wait_cnt = 0;
    pending  = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin pending = 1'b0; continue; end
      if (acc_seen) begin pending = 1'b1; wait_cnt = 0; end
      if (pending) begin
        if (cmd_ready) begin
          pending = 1'b0;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: depth %0d with no expected entry", depth);
          end else begin
            e = exp_q.pop_front();
            chk("busy_cycles", 64'(wait_cnt), 64'(e.lat));
            chk("depth", 64'(depth), 64'(e.d));
            if (e.d >= 1) chk("stack0", 64'(stack0), 64'(e.s0));
            if (e.d >= 2) chk("stack1", 64'(stack1), 64'(e.s1));
            chk("err_overflow", 64'(err_overflow), 64'(e.o));
            chk("err_underflow", 64'(err_underflow), 64'(e.u));
`ifdef RPN_SAT_EN
            chk("err_saturate", 64'(err_saturate), 64'(e.sat));
`endif
          end
        end else begin
          wait_cnt++;
          if (wait_cnt > 100) begin
            checks++; errors++;
            $display("FAIL completion_timeout: cmd_ready low %0d cycles, required <= %0d",
                     wait_cnt, DW + 1);
            pending = 1'b0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] v;
    logic [2:0]    rop;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_depth", 64'(depth), 64'(0));
    chk("rst_stack0", 64'(stack0), 64'(0));
    chk("rst_stack1", 64'(stack1), 64'(0));
    chk("rst_ovf", 64'(err_overflow), 64'(0));
    chk("rst_udf", 64'(err_underflow), 64'(0));
    chk("rst_ready", 64'(cmd_ready), 64'(1));
    @(negedge clock);
    reset_n = 1'b1;

    // 5 - 3
    issue(RPN_PUSH, 32'd5, 1'b0);
    issue(RPN_PUSH, 32'd3, 1'b0);
    issue(RPN_SUB, '0, 1'b0);
    // wide multiply: low word of 0x1_0001_0000
    issue(RPN_PUSH, 32'h0001_0000, 1'b0);
    issue(RPN_PUSH, 32'h0001_0001, 1'b0);
    issue(RPN_MUL, '0, 1'b0);
    drain();
    // overflow at DEPTH
    issue(RPN_POP, '0, 1'b0);
    issue(RPN_POP, '0, 1'b0);
    for (int i = 1; i <= DP; i++) issue(RPN_PUSH, DW'(i), 1'b0);
    issue(RPN_PUSH, 32'd9, 1'b0);
    drain();
    chk("ovf_set", 64'(err_overflow), 64'(1));
    clear_errors();
    // underflow on empty stack
    for (int i = 0; i < DP; i++) issue(RPN_POP, '0, 1'b0);
    issue(RPN_ADD, '0, 1'b0);
    drain();
    chk("udf_set", 64'(err_underflow), 64'(1));
    clear_errors();
    // DUP / SWAP / POP, then signed boundary add
    issue(RPN_PUSH, 32'd7, 1'b0);
    issue(RPN_DUP, '0, 1'b0);
    issue(RPN_SWAP, '0, 1'b0);
    issue(RPN_POP, '0, 1'b0);
    issue(RPN_PUSH, 32'h7FFF_FFFF, 1'b0);
    issue(RPN_PUSH, 32'd1, 1'b0);
    issue(RPN_ADD, '0, 1'b0);
    issue(RPN_PUSH, 32'h8000_0000, 1'b0);
    issue(RPN_PUSH, 32'd1, 1'b0);
    issue(RPN_SUB, '0, 1'b0);

    // randomized mix with occasional error clears
    for (int k = 0; k < 300; k++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       v = 32'h7FFF_FFFF;
        1:       v = 32'h8000_0000;
        2:       v = DW'($urandom_range(0, 15));
        default: v = $urandom;
      endcase
      issue(rop, v, ($urandom_range(0, 5) == 0));
    end
    drain();

    // reset during a multiply
    issue(RPN_PUSH, 32'd3, 1'b0);
    issue(RPN_PUSH, 32'd4, 1'b0);
    drain();
    cmd_valid = 1'b1; cmd_op = 3'(RPN_MUL);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0; cmd_op = 3'd0;
    repeat (10) @(posedge clock);
    #1;
    chk("mul_busy", 64'(cmd_ready), 64'(0));
    reset_n = 1'b0;
    #1;
    chk("abort_depth", 64'(depth), 64'(0));
    chk("abort_stack0", 64'(stack0), 64'(0));
    chk("abort_stack1", 64'(stack1), 64'(0));
    chk("abort_flags", 64'({err_overflow, err_underflow}), 64'(0));
    chk("abort_ready", 64'(cmd_ready), 64'(1));
    m.delete();
    exp_q.delete();
    m_o = 1'b0; m_u = 1'b0; m_s = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_reset_ready", 64'(cmd_ready), 64'(1));
    issue(RPN_PUSH, 32'd11, 1'b0);
    issue(RPN_PUSH, 32'd6, 1'b0);
    issue(RPN_MUL, '0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
